// File: rtl/sram_march_bist.sv
// March C- built-in self-test initiator for a single-port SRAM with a combinational read port.
// Each address gets one read-compare-write cycle per element; the first mismatch is captured and ends the run.
module sram_march_bist #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  bist_busy,
  output logic                  bist_done,
  output logic                  bist_fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, E0_W0, E1_R0W1, E2_R1W0, E3_R0W1, E4_R1W0, E5_R0, DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic                  w_active;
  logic                  w_check;
  logic                  w_descend;
  logic                  w_last;
  logic                  w_mismatch;
  logic [DATA_WIDTH-1:0] w_expect;

  // NOTE: every signal gets a value before any condition so no latch is inferred.
  always_comb begin
    w_active   = r_state inside {E0_W0, E1_R0W1, E2_R1W0, E3_R0W1, E4_R1W0, E5_R0};
    w_check    = r_state inside {E1_R0W1, E2_R1W0, E3_R0W1, E4_R1W0, E5_R0};
    w_descend  = r_state inside {E3_R0W1, E4_R1W0, E5_R0};
    w_last     = w_descend ? (r_addr == '0) : (r_addr == ADDR_LAST);
    w_expect   = '0;
    if (r_state inside {E2_R1W0, E4_R1W0}) w_expect = '1;
    // The old word is still visible on mem_rdata because the write lands at the next edge.
    w_mismatch = w_check && (mem_rdata != w_expect);
    mem_we     = w_active && (r_state != E5_R0) && !w_mismatch;
    mem_addr   = w_active ? r_addr : '0;
    mem_wdata  = '0;
    if (r_state inside {E1_R0W1, E3_R0W1}) mem_wdata = '1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      bist_busy <= 1'b0;
      bist_done <= 1'b0;
      bist_fail <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state   <= E0_W0;
            r_addr    <= '0;
            bist_busy <= 1'b1;
            bist_done <= 1'b0;
            bist_fail <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
          end
        end
        default: begin
          if (w_mismatch) begin
            r_state   <= DONE;
            r_addr    <= '0;
            bist_busy <= 1'b0;
            bist_done <= 1'b1;
            bist_fail <= 1'b1;
            fail_addr <= r_addr;
            fail_data <= mem_rdata;
          end else if (w_last) begin
            case (r_state)
              E0_W0:   begin r_state <= E1_R0W1; r_addr <= '0;        end
              E1_R0W1: begin r_state <= E2_R1W0; r_addr <= '0;        end
              E2_R1W0: begin r_state <= E3_R0W1; r_addr <= ADDR_LAST; end
              E3_R0W1: begin r_state <= E4_R1W0; r_addr <= ADDR_LAST; end
              E4_R1W0: begin r_state <= E5_R0;   r_addr <= ADDR_LAST; end
              default: begin
                r_state   <= DONE;
                r_addr    <= '0;
                bist_busy <= 1'b0;
                bist_done <= 1'b1;
              end
            endcase
          end else begin
            r_addr <= w_descend ? (r_addr - 1'b1) : (r_addr + 1'b1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_march_bist.sv
// Self-checking bench for sram_march_bist: a fault-injecting SRAM model, a table of directed
// fault cases, randomized faults checked against an algorithmic March C- model, and corner sequences.
module tb_sram_march_bist;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  typedef enum int {F_NONE, F_SA1, F_SA0, F_CPL} fault_e;

  typedef struct {
    fault_e kind;
    int     faddr;
    int     fbit;
    int     vict;
    bit     exp_fail;
    int     exp_addr;
    int     exp_data;
    int     exp_busy;
    int     exp_we;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          bist_busy, bist_done, bist_fail;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .bist_busy(bist_busy), .bist_done(bist_done), .bist_fail(bist_fail),
    .fail_addr(fail_addr), .fail_data(fail_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // SRAM with one injectable fault: stuck-at on read, or a 1->0 write to the aggressor
  // address (f_addr) that toggles bit f_bit of the victim address (f_vict).
  fault_e        f_kind = F_NONE;
  int            f_addr = 0;
  int            f_bit  = 0;
  int            f_vict = 0;
  bit            clr_mem;
  logic [DW-1:0] mem [DEPTH];

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      if (f_kind == F_CPL && int'(mem_addr) == f_addr && mem_wdata == '0 && mem[mem_addr] != '0)
        mem[f_vict][f_bit] <= ~mem[f_vict][f_bit];
    end
  end

  always_comb begin
    mem_rdata = mem[mem_addr];
    if (f_kind == F_SA1 && int'(mem_addr) == f_addr) mem_rdata[f_bit] = 1'b1;
    else if (f_kind == F_SA0 && int'(mem_addr) == f_addr) mem_rdata[f_bit] = 1'b0;
  end

  // Minimum-size instance (two words) against a fault-free memory.
  logic       start1;
  logic       busy1, done1, fail1, we1;
  logic [0:0] faddr1, addr1;
  logic [3:0] fdata1, wdata1, rdata1;
  logic [3:0] mem1 [2];

  sram_march_bist #(.ADDR_WIDTH(1), .DATA_WIDTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .bist_busy(busy1), .bist_done(done1), .bist_fail(fail1),
    .fail_addr(faddr1), .fail_data(fdata1),
    .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1), .mem_rdata(rdata1)
  );

  always @(posedge clk) if (we1) mem1[addr1] <= wdata1;
  assign rdata1 = mem1[addr1];

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // March C- run described as a list of elements over a plain array.
  function automatic void model(input fault_e kind, input int fa, input int fb, input int fv,
                                output bit fail, output int faddr, output int fdata,
                                output int busy, output int we);
    logic [DW-1:0] m [DEPTH];
    logic [DW-1:0] r, exp_v, wv;
    int a;
    for (int i = 0; i < DEPTH; i++) m[i] = '0;
    fail = 1'b0; faddr = 0; fdata = 0; busy = 0; we = 0;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < DEPTH; k++) begin
        a = (e < 3) ? k : DEPTH - 1 - k;
        busy++;
        r = m[a];
        if (kind == F_SA1 && a == fa) r[fb] = 1'b1;
        if (kind == F_SA0 && a == fa) r[fb] = 1'b0;
        exp_v = (e == 2 || e == 4) ? {DW{1'b1}} : {DW{1'b0}};
        if (e > 0 && r != exp_v) begin
          fail = 1'b1; faddr = a; fdata = int'(r);
          return;
        end
        if (e < 5) begin
          wv = (e == 1 || e == 3) ? {DW{1'b1}} : {DW{1'b0}};
          we++;
          if (kind == F_CPL && a == fa && wv == '0 && m[a] != '0) m[fv][fb] = ~m[fv][fb];
          m[a] = wv;
        end
      end
    end
  endfunction

  task automatic clear_mem();
    @(negedge clk); clr_mem = 1'b1;
    @(negedge clk); clr_mem = 1'b0;
  endtask

  // Start a run and count busy / write cycles until bist_done, with a cycle budget.
  task automatic run_bist(input bit hold, output int busy_cyc, output int we_cyc);
    busy_cyc = 0; we_cyc = 0;
    @(negedge clk); start = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (i == 0) check("start_clears", {bist_done, bist_fail, fail_addr, fail_data}, 0);
      if (bist_busy) busy_cyc++;
      if (mem_we) we_cyc++;
      if (bist_done) break;
    end
    check("done_within_budget", bist_done, 1);
  endtask

  task automatic run_and_compare(input string tag, input vec_t v);
    int busy_cyc, we_cyc;
    f_kind = v.kind; f_addr = v.faddr; f_bit = v.fbit; f_vict = v.vict;
    clear_mem();
    run_bist(1'b0, busy_cyc, we_cyc);
    check({tag, "_fail"}, bist_fail, v.exp_fail);
    check({tag, "_addr"}, fail_addr, v.exp_addr);
    check({tag, "_data"}, fail_data, v.exp_data);
    check({tag, "_busy_cycles"}, busy_cyc, v.exp_busy);
    check({tag, "_we_cycles"}, we_cyc, v.exp_we);
  endtask

  initial begin
    vec_t vecs [4];
    vec_t rv;
    int   busy_cyc, we_cyc;
    int   b1;

    vecs[0] = '{F_NONE, 0,  0, 0, 1'b0, 0,  8'h00, 96, 80};
    vecs[1] = '{F_SA1,  5,  3, 0, 1'b1, 5,  8'h08, 22, 21};
    vecs[2] = '{F_SA0,  10, 0, 0, 1'b1, 10, 8'hFE, 43, 42};
    vecs[3] = '{F_CPL,  2,  0, 1, 1'b1, 1,  8'h01, 63, 62};

    rst = 1'b1; start = 1'b0; start1 = 1'b0; clr_mem = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {bist_busy, bist_done, bist_fail, fail_addr, fail_data, mem_we, mem_addr, mem_wdata}, 0);
    rst = 1'b0; clr_mem = 1'b0;

    for (int i = 0; i < 4; i++) run_and_compare($sformatf("vec%0d", i), vecs[i]);

    for (int n = 0; n < 12; n++) begin
      rv.kind  = fault_e'($urandom_range(0, 3));
      rv.faddr = $urandom_range(0, DEPTH - 1);
      rv.fbit  = $urandom_range(0, DW - 1);
      rv.vict  = (rv.faddr + $urandom_range(1, DEPTH - 1)) % DEPTH;
      model(rv.kind, rv.faddr, rv.fbit, rv.vict,
            rv.exp_fail, rv.exp_addr, rv.exp_data, rv.exp_busy, rv.exp_we);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_and_compare($sformatf("rand%0d", n), rv);
    end

    // Asynchronous reset in the middle of a run, then a clean rerun.
    f_kind = F_NONE;
    clear_mem();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (39) @(negedge clk);
    check("busy_before_reset", bist_busy, 1);
    #2 rst = 1'b1;
    #1 check("midrun_reset_outputs",
             {bist_busy, bist_done, bist_fail, fail_addr, fail_data, mem_we, mem_addr, mem_wdata}, 0);
    @(negedge clk); rst = 1'b0;
    run_bist(1'b0, busy_cyc, we_cyc);
    check("after_reset_busy_cycles", busy_cyc, 96);
    check("after_reset_fail", bist_fail, 0);

    // start held high: no restart while busy, immediate re-run after DONE.
    clear_mem();
    run_bist(1'b1, busy_cyc, we_cyc);
    check("hold_busy_cycles", busy_cyc, 96);
    check("hold_fail", bist_fail, 0);
    @(negedge clk);
    check("hold_rerun_busy_done", {bist_busy, bist_done}, 2'b10);
    start = 1'b0;
    for (int i = 0; i < 200 && !bist_done; i++) @(negedge clk);
    check("hold_rerun_done", {bist_done, bist_fail}, 2'b10);

    // Two-word instance: each element spans two cycles.
    b1 = 0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int i = 0; i < 100 && !done1; i++) begin
      if (busy1) b1++;
      @(negedge clk);
    end
    check("aw1_busy_cycles", b1, 12);
    check("aw1_done_fail", {done1, fail1}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
